// File: rtl/regfile_wb.sv
// regfile_wb: 2**ADDR_W x DATA_W register file for the writeback/decode boundary, with r0 hard-wired to 0.
// Define WB_BYPASS_EN to forward same-cycle write data to the two ID read ports.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_RegWrite,
  input  logic [ADDR_W-1:0] WB_WriteReg,
  input  logic [DATA_W-1:0] WB_RegDatain,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              wr_accept;
  logic [DATA_W-1:0] rd1_stored;
  logic [DATA_W-1:0] rd2_stored;

  // Reset is checked separately in the register process, so it also wins over this strobe.
  assign wr_accept = WB_RegWrite && (WB_WriteReg != '0);

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_accept) begin
      regs_d[WB_WriteReg] = WB_RegDatain;
      if (wr_count_q != '1) begin
        wr_count_d = wr_count_q + 32'd1;
      end
    end
    regs_d[0] = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the storage array is reset in full because the file must read 0 everywhere after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rd1_stored = (ID_rs == '0) ? '0 : regs_q[ID_rs];
    rd2_stored = (ID_rt == '0) ? '0 : regs_q[ID_rt];
    dbg_data   = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  end

`ifdef WB_BYPASS_EN
  // Forwarding ignores rst; the reset edge still clears the stored value read afterwards.
  always_comb begin
    ID_ReadData1 = (wr_accept && (ID_rs == WB_WriteReg)) ? WB_RegDatain : rd1_stored;
    ID_ReadData2 = (wr_accept && (ID_rt == WB_WriteReg)) ? WB_RegDatain : rd2_stored;
  end
`else
  always_comb begin
    ID_ReadData1 = rd1_stored;
    ID_ReadData2 = rd2_stored;
  end
`endif

  assign wr_count = wr_count_q;

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Parameter DATA_W, 32: width of each register and data port.
REQ-003 Parameter ADDR_W, 5: register address width; the file holds 2**ADDR_W registers.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port WB_RegWrite, input, 1: write strobe from the writeback stage.
REQ-007 Port WB_WriteReg, input, ADDR_W: destination register address.
REQ-008 Port WB_RegDatain, input, DATA_W: write data from the writeback select.
REQ-009 Port ID_rs, input, ADDR_W: read address, port 1.
REQ-010 Port ID_rt, input, ADDR_W: read address, port 2.
REQ-011 Port ID_ReadData1, output, DATA_W: read data, port 1.
REQ-012 Port ID_ReadData2, output, DATA_W: read data, port 2.
REQ-013 Port dbg_addr, input, ADDR_W: debug read address.
REQ-014 Port dbg_data, output, DATA_W: debug read data; never bypassed.
REQ-015 Port wr_count, output, 32: count of accepted writes.

Function
REQ-016 A write SHALL be accepted on a rising edge when WB_RegWrite=1, WB_WriteReg!=0 and rst=0.
REQ-017 An accepted write SHALL update register WB_WriteReg with WB_RegDatain; the new value is visible one cycle after that edge.
REQ-018 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored and SHALL NOT be counted.
REQ-019 All three read ports SHALL be combinational (zero-latency) functions of their address and the stored state.
REQ-020 Both read ports SHALL return the same value when ID_rs equals ID_rt.
REQ-021 wr_count SHALL increment by 1 on each accepted write.
REQ-022 wr_count SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap to 0.
REQ-023 With WB_RegWrite=0, no register and no wr_count SHALL change.
REQ-024 Write data of X-free width DATA_W SHALL be stored unmodified, with no sign or zero extension.

Reset
REQ-025 When rst=1 on a rising edge, all registers SHALL become 0 and wr_count SHALL become 0.
REQ-026 Reset SHALL take priority over a simultaneous write: that write SHALL be dropped and SHALL NOT be counted.
REQ-027 Deasserting rst mid-operation SHALL let the first write on the following edge be accepted normally.
REQ-028 After reset, ID_ReadData1, ID_ReadData2 and dbg_data SHALL read 0 for every address.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL control a same-cycle write-through bypass.
REQ-030 With WB_BYPASS_EN defined, ID_ReadData1 and ID_ReadData2 SHALL return WB_RegDatain when their address equals WB_WriteReg, WB_RegWrite=1 and the address is not 0; otherwise they SHALL return the stored value.
REQ-031 With WB_BYPASS_EN undefined, both ports SHALL always return the stored value, i.e. the pre-write value during a same-cycle write.
REQ-032 The bypass SHALL remain active while rst=1, but reads SHALL still show 0 after the reset edge.
REQ-033 The bypass SHALL NOT apply to dbg_data in either configuration.

Verification
REQ-034 Reset, then write r5=32'hDEADBEEF -> next cycle ID_rs=5 reads DEADBEEF and wr_count=1.
REQ-035 Write r0=32'h12345678 -> r0 reads 0 and wr_count is unchanged.
REQ-036 Hold WB_RegWrite=1, WB_WriteReg=7, WB_RegDatain=32'hA5A5A5A5 with ID_rt=7 and r7=32'h11 -> same cycle ID_ReadData2=A5A5A5A5 with WB_BYPASS_EN defined and 00000011 without it; dbg_data at address 7 reads 00000011 in both builds.
REQ-037 Assert rst together with a write of r3=32'hFF -> r3=0 and wr_count=0 after the edge.
REQ-038 Force wr_count to 32'hFFFFFFFE, then perform 3 accepted writes -> wr_count=FFFFFFFF and holds.
REQ-039 Set ID_rs=ID_rt=9 with r9=32'h55 -> both ports read 00000055.
